// File: rtl/notif_arbiter_if.sv
// Notification bus between event sources and the LED manager FIFO.
// Carries the per-channel input strobes/codes and the registered
// valid/ready output. The arbiter takes the slave view; the
// source/consumer side takes the master view.
interface notif_arbiter_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 4,
   parameter int CH_W   = $clog2(NUM_CH)
);
   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH*DATA_W-1:0] in_data;
   logic [NUM_CH-1:0]        ch_mask;
   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_W-1:0]        out_data;
   logic [CH_W-1:0]          out_ch;

   modport master (
      output in_valid, in_data, ch_mask, out_ready,
      input  out_valid, out_data, out_ch
   );

   modport slave (
      input  in_valid, in_data, ch_mask, out_ready,
      output out_valid, out_data, out_ch
   );
endinterface

// File: rtl/notif_arbiter.sv
// N-channel notification collector. Every channel owns a small circular
// queue so that events arriving together are queued rather than lost.
// A fixed-priority or round-robin arbiter drains the queues into one
// registered valid/ready output. Drops are flagged per channel (sticky)
// and counted in a saturating 8-bit counter.

// One channel queue: circular buffer with an occupancy counter.
// A push into a full queue is still accepted when the same edge pops,
// because the slot being read is freed at that edge.
module notif_chq #(
   parameter int DATA_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_req,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic              empty,
   output logic [DATA_W-1:0] head,
   output logic              drop
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    cnt;
   logic              full;
   logic              do_push;

   assign full    = (cnt == (PTR_W+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push_req & (~full | pop);
   assign drop    = push_req & full & ~pop;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; DEPTH is a power of 2 so the
   // pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

module notif_arbiter #(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 4,
   parameter int DEPTH   = 4,
   parameter int RR_MODE = 0,
   localparam int CH_W   = $clog2(NUM_CH),
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   notif_arbiter_if.slave    bus,
   output logic [NUM_CH-1:0] overflow,
   output logic [7:0]        drop_cnt,
   input  logic              clr_stat
);
   logic [NUM_CH-1:0]             push_req;
   logic [NUM_CH-1:0]             pop;
   logic [NUM_CH-1:0]             empty;
   logic [NUM_CH-1:0]             drop;
   logic [NUM_CH-1:0][DATA_W-1:0] head;

   logic [CH_W-1:0]   gnt;
   logic              gnt_vld;
   logic [CH_W-1:0]   last_grant;
   logic              load;
   logic              take;

   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [CH_W-1:0]   out_ch_q;

   logic [3:0]        n_drop;
   logic [9:0]        drop_sum;
   logic [7:0]        drop_nxt;
   logic [NUM_CH-1:0] ovf_nxt;

   // Masked channels never push; already-queued entries still drain.
   assign push_req = bus.in_valid & ~bus.ch_mask;

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_ch
         notif_chq #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
         ) u_q (
            .clk      (clk),
            .rst_n    (rst_n),
            .push_req (push_req[g]),
            .din      (bus.in_data[g*DATA_W +: DATA_W]),
            .pop      (pop[g]),
            .empty    (empty[g]),
            .head     (head[g]),
            .drop     (drop[g])
         );
      end
   endgenerate

   // Winner selection on pre-push queue state. Both searches walk in
   // reverse so the last hit is the highest-priority candidate.
   always_comb begin
      int idx;
      gnt     = '0;
      gnt_vld = 1'b0;
      idx     = 0;
      if (RR_MODE == 0) begin
         for (int i = NUM_CH-1; i >= 0; i--) begin
            if (!empty[i]) begin
               gnt     = CH_W'(i);
               gnt_vld = 1'b1;
            end
         end
      end else begin
         for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_CH;
            if (!empty[idx]) begin
               gnt     = CH_W'(idx);
               gnt_vld = 1'b1;
            end
         end
      end
   end

   // Output register may load when empty or when its event is leaving.
   assign load = ~out_valid_q | bus.out_ready;
   assign take = load & gnt_vld;
   assign pop  = take ? ({{(NUM_CH-1){1'b0}}, 1'b1} << gnt) : '0;

   // Output register; holds steady under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
      end else if (load) begin
         out_valid_q <= gnt_vld;
         if (gnt_vld) begin
            out_data_q <= head[gnt];
            out_ch_q   <= gnt;
         end
      end
   end

   // Round-robin pointer; moves only when a grant is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    last_grant <= CH_W'(NUM_CH-1);
      else if (take) last_grant <= gnt;
   end

   // Drop statistics: a clear in the same cycle as drops keeps the drops.
   always_comb begin
      n_drop = '0;
      for (int i = 0; i < NUM_CH; i++) n_drop = n_drop + {3'b000, drop[i]};
      drop_sum = (clr_stat ? 10'd0 : {2'b00, drop_cnt}) + {6'd0, n_drop};
      drop_nxt = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
      ovf_nxt  = (clr_stat ? '0 : overflow) | drop;
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= '0;
         drop_cnt <= '0;
      end else begin
         overflow <= ovf_nxt;
         drop_cnt <= drop_nxt;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_notif_arbiter.sv
// Directed bench: a fixed-priority and a round-robin instance receive the
// same stimulus. A vector table covers single event, priority order,
// backpressure/overflow and mask/clear; hand sequences cover round robin,
// masked drain, drop saturation and asynchronous reset.
module tb_notif_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  iv = '0;
   logic [15:0] d = '0;
   logic [3:0]  msk = '0;
   logic        rdy = 1'b0;
   logic        clr = 1'b0;

   logic [3:0]  fp_ovf, rr_ovf;
   logic [7:0]  fp_drop, rr_drop;

   int n_vec = 0;
   int n_bad = 0;

   notif_arbiter_if #(.NUM_CH(4), .DATA_W(4)) if_fp ();
   notif_arbiter_if #(.NUM_CH(4), .DATA_W(4)) if_rr ();

   assign if_fp.in_valid  = iv;
   assign if_fp.in_data   = d;
   assign if_fp.ch_mask   = msk;
   assign if_fp.out_ready = rdy;
   assign if_rr.in_valid  = iv;
   assign if_rr.in_data   = d;
   assign if_rr.ch_mask   = msk;
   assign if_rr.out_ready = rdy;

   notif_arbiter #(.NUM_CH(4), .DATA_W(4), .DEPTH(4), .RR_MODE(0)) u_fp (
      .clk(clk), .rst_n(rst_n), .bus(if_fp.slave),
      .overflow(fp_ovf), .drop_cnt(fp_drop), .clr_stat(clr));

   notif_arbiter #(.NUM_CH(4), .DATA_W(4), .DEPTH(4), .RR_MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .bus(if_rr.slave),
      .overflow(rr_ovf), .drop_cnt(rr_drop), .clr_stat(clr));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  iv;
      logic [15:0] d;
      logic [3:0]  msk;
      logic        rdy;
      logic        clr;
      logic        ev;
      logic [3:0]  ed;
      logic [1:0]  ech;
      logic [3:0]  eovf;
      logic [7:0]  edrop;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [3:0] a_iv, input logic [15:0] a_d,
                      input logic [3:0] a_msk, input logic a_rdy, input logic a_clr,
                      input logic a_ev, input logic [3:0] a_ed, input logic [1:0] a_ech,
                      input logic [3:0] a_eovf, input logic [7:0] a_edrop);
      vec_t v;
      v.iv = a_iv; v.d = a_d; v.msk = a_msk; v.rdy = a_rdy; v.clr = a_clr;
      v.ev = a_ev; v.ed = a_ed; v.ech = a_ech; v.eovf = a_eovf; v.edrop = a_edrop;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic do_reset();
      iv = '0; d = '0; msk = '0; rdy = 1'b0; clr = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic [3:0] a_iv, input logic [15:0] a_d,
                        input logic [3:0] a_msk, input logic a_rdy);
      @(negedge clk);
      iv = a_iv; d = a_d; msk = a_msk; rdy = a_rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int rr_ch[5];
      int rr_d[5];
      int fp_ch[5];
      int fp_d[5];

      // Single event, latency one cycle after the push edge
      add(4'b0100, 16'h0A00, 4'h0, 1, 0, 0, 4'h0, 2'd0, 4'b0000, 8'd0);
      add(4'b0000, 16'h0000, 4'h0, 1, 0, 1, 4'hA, 2'd2, 4'b0000, 8'd0);
      add(4'b0000, 16'h0000, 4'h0, 1, 0, 0, 4'h0, 2'd0, 4'b0000, 8'd0);
      // Fixed priority, all four channels at once
      add(4'b1111, 16'h4321, 4'h0, 1, 0, 0, 4'h0, 2'd0, 4'b0000, 8'd0);
      add(4'b0000, 16'h0000, 4'h0, 1, 0, 1, 4'h1, 2'd0, 4'b0000, 8'd0);
      add(4'b0000, 16'h0000, 4'h0, 1, 0, 1, 4'h2, 2'd1, 4'b0000, 8'd0);
      add(4'b0000, 16'h0000, 4'h0, 1, 0, 1, 4'h3, 2'd2, 4'b0000, 8'd0);
      add(4'b0000, 16'h0000, 4'h0, 1, 0, 1, 4'h4, 2'd3, 4'b0000, 8'd0);
      add(4'b0000, 16'h0000, 4'h0, 1, 0, 0, 4'h0, 2'd0, 4'b0000, 8'd0);
      // Backpressure: ch1 pushes 7 events, 1 held + 4 queued + 2 dropped
      add(4'b0010, 16'h0010, 4'h0, 0, 0, 0, 4'h0, 2'd0, 4'b0000, 8'd0);
      add(4'b0010, 16'h0020, 4'h0, 0, 0, 1, 4'h1, 2'd1, 4'b0000, 8'd0);
      add(4'b0010, 16'h0030, 4'h0, 0, 0, 1, 4'h1, 2'd1, 4'b0000, 8'd0);
      add(4'b0010, 16'h0040, 4'h0, 0, 0, 1, 4'h1, 2'd1, 4'b0000, 8'd0);
      add(4'b0010, 16'h0050, 4'h0, 0, 0, 1, 4'h1, 2'd1, 4'b0000, 8'd0);
      add(4'b0010, 16'h0060, 4'h0, 0, 0, 1, 4'h1, 2'd1, 4'b0010, 8'd1);
      add(4'b0010, 16'h0070, 4'h0, 0, 0, 1, 4'h1, 2'd1, 4'b0010, 8'd2);
      add(4'b0000, 16'h0000, 4'h0, 1, 0, 1, 4'h2, 2'd1, 4'b0010, 8'd2);
      add(4'b0000, 16'h0000, 4'h0, 1, 0, 1, 4'h3, 2'd1, 4'b0010, 8'd2);
      add(4'b0000, 16'h0000, 4'h0, 1, 0, 1, 4'h4, 2'd1, 4'b0010, 8'd2);
      add(4'b0000, 16'h0000, 4'h0, 1, 0, 1, 4'h5, 2'd1, 4'b0010, 8'd2);
      add(4'b0000, 16'h0000, 4'h0, 1, 0, 0, 4'h0, 2'd0, 4'b0010, 8'd2);
      // Masked ch0 strobe: not queued, not counted
      add(4'b0001, 16'h0007, 4'h1, 1, 0, 0, 4'h0, 2'd0, 4'b0010, 8'd2);
      add(4'b0000, 16'h0000, 4'h1, 1, 0, 0, 4'h0, 2'd0, 4'b0010, 8'd2);
      // Refill ch1, then clear in the same cycle as a new drop
      add(4'b0010, 16'h0010, 4'h0, 0, 0, 0, 4'h0, 2'd0, 4'b0010, 8'd2);
      add(4'b0010, 16'h0020, 4'h0, 0, 0, 1, 4'h1, 2'd1, 4'b0010, 8'd2);
      add(4'b0010, 16'h0030, 4'h0, 0, 0, 1, 4'h1, 2'd1, 4'b0010, 8'd2);
      add(4'b0010, 16'h0040, 4'h0, 0, 0, 1, 4'h1, 2'd1, 4'b0010, 8'd2);
      add(4'b0010, 16'h0050, 4'h0, 0, 0, 1, 4'h1, 2'd1, 4'b0010, 8'd2);
      add(4'b0010, 16'h0060, 4'h0, 0, 1, 1, 4'h1, 2'd1, 4'b0010, 8'd1);
      add(4'b0000, 16'h0000, 4'h0, 0, 1, 1, 4'h1, 2'd1, 4'b0000, 8'd0);

      do_reset();
      chk("reset_valid", 32'(if_fp.out_valid), 32'd0);
      chk("reset_ovf",   32'(fp_ovf),          32'd0);
      chk("reset_drop",  32'(fp_drop),         32'd0);

      foreach (vq[i]) begin
         @(negedge clk);
         iv = vq[i].iv; d = vq[i].d; msk = vq[i].msk; rdy = vq[i].rdy; clr = vq[i].clr;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_valid", i), 32'(if_fp.out_valid), 32'(vq[i].ev));
         if (vq[i].ev) begin
            chk($sformatf("v%0d_data", i), 32'(if_fp.out_data), 32'(vq[i].ed));
            chk($sformatf("v%0d_ch", i),   32'(if_fp.out_ch),   32'(vq[i].ech));
         end
         chk($sformatf("v%0d_ovf", i),  32'(fp_ovf),  32'(vq[i].eovf));
         chk($sformatf("v%0d_drop", i), 32'(fp_drop), 32'(vq[i].edrop));
      end
      @(negedge clk);
      clr = 1'b0;

      // Round robin: ch0 holds 1,2,3 and ch3 holds 9,A,B
      do_reset();
      drive(4'b1001, 16'h9001, 4'h0, 0);
      chk("rr_first_idle", 32'(if_rr.out_valid), 32'd0);
      drive(4'b1001, 16'hA002, 4'h0, 0);
      chk("rr_first_ch",   32'(if_rr.out_ch),   32'd0);
      chk("rr_first_data", 32'(if_rr.out_data), 32'h1);
      chk("fp_first_data", 32'(if_fp.out_data), 32'h1);
      drive(4'b1001, 16'hB003, 4'h0, 0);
      chk("rr_hold_valid", 32'(if_rr.out_valid), 32'd1);
      chk("rr_hold_data",  32'(if_rr.out_data),  32'h1);
      rr_ch = '{3, 0, 3, 0, 3};
      rr_d  = '{9, 2, 10, 3, 11};
      fp_ch = '{0, 0, 3, 3, 3};
      fp_d  = '{2, 3, 9, 10, 11};
      for (int k = 0; k < 5; k++) begin
         drive(4'b0000, 16'h0000, 4'h0, 1);
         chk($sformatf("rr_seq%0d_ch", k),   32'(if_rr.out_ch),   32'(rr_ch[k]));
         chk($sformatf("rr_seq%0d_data", k), 32'(if_rr.out_data), 32'(rr_d[k]));
         chk($sformatf("fp_seq%0d_ch", k),   32'(if_fp.out_ch),   32'(fp_ch[k]));
         chk($sformatf("fp_seq%0d_data", k), 32'(if_fp.out_data), 32'(fp_d[k]));
      end
      drive(4'b0000, 16'h0000, 4'h0, 1);
      chk("rr_seq_end", 32'(if_rr.out_valid), 32'd0);
      chk("fp_seq_end", 32'(if_fp.out_valid), 32'd0);

      // Masking gates pushes only; a queued ch0 event still drains
      do_reset();
      drive(4'b0001, 16'h0005, 4'h0, 0);
      drive(4'b0001, 16'h0006, 4'h0, 0);
      chk("mdrain_first", 32'(if_fp.out_data), 32'h5);
      drive(4'b0001, 16'h0007, 4'h1, 1);
      chk("mdrain_valid", 32'(if_fp.out_valid), 32'd1);
      chk("mdrain_data",  32'(if_fp.out_data),  32'h6);
      drive(4'b0000, 16'h0000, 4'h1, 1);
      chk("mdrain_empty", 32'(if_fp.out_valid), 32'd0);
      chk("mdrain_drop",  32'(fp_drop),         32'd0);

      // Multi-channel drops and saturation, then async reset mid-stream
      do_reset();
      for (int n = 1; n <= 80; n++) begin
         drive(4'b1111, 16'h5555, 4'h0, 0);
         if (n == 5) begin
            chk("multi_drop5", 32'(fp_drop), 32'd3);
            chk("multi_ovf5",  32'(fp_ovf),  32'b1110);
         end
         if (n == 6) begin
            chk("multi_drop6", 32'(fp_drop), 32'd7);
            chk("rr_drop6",    32'(rr_drop), 32'd7);
            chk("multi_ovf6",  32'(fp_ovf),  32'b1111);
         end
      end
      chk("sat_drop_fp", 32'(fp_drop), 32'd255);
      chk("sat_drop_rr", 32'(rr_drop), 32'd255);
      chk("sat_valid",   32'(if_fp.out_valid), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(if_fp.out_valid), 32'd0);
      chk("async_drop",  32'(fp_drop),         32'd0);
      chk("async_ovf",   32'(fp_ovf),          32'd0);
      chk("async_rr",    32'(if_rr.out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      iv = '0; rdy = 1'b1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(4'b0000, 16'h0000, 4'h0, 1);
         chk($sformatf("post_rst_empty%0d", k), 32'(if_fp.out_valid | if_rr.out_valid), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
